// File: rtl/jk_ff_checker.sv
//------------------------------------------------------------------------------
// Module  : jk_ff_checker
// Purpose : Passive checker that tracks a golden JK model against a DUT's q.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module jk_ff_checker #(
  parameter int ERR_CNT_W   = 8,
  parameter int CHK_CNT_W   = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 j,
  input  logic                 k,
  input  logic                 q,
  output logic                 synced,
  output logic                 q_exp,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [CHK_CNT_W-1:0] chk_cnt,
  output logic [CHK_CNT_W-1:0] first_err_cyc
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_CHECK  = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0] C_ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CHK_CNT_W-1:0] C_CHK_ONE = {{(CHK_CNT_W-1){1'b0}}, 1'b1};

  state_t                 r_state, w_state_nxt;
  logic                   r_q_exp, w_q_exp_nxt;
  logic                   r_err_flag, w_err_flag_nxt;
  logic [ERR_CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
  logic [CHK_CNT_W-1:0]   r_chk_cnt, w_chk_cnt_nxt;
  logic [CHK_CNT_W-1:0]   r_first_err, w_first_err_nxt;
  logic                   w_mismatch;
  logic [ERR_CNT_W-1:0]   w_err_inc;
  logic [CHK_CNT_W-1:0]   w_chk_inc;

  // 4-state compare so an X/Z on q is flagged rather than silently passing
  assign w_mismatch = (q !== r_q_exp);
  assign w_err_inc  = (&r_err_cnt) ? r_err_cnt : r_err_cnt + C_ERR_ONE;
  assign w_chk_inc  = (&r_chk_cnt) ? r_chk_cnt : r_chk_cnt + C_CHK_ONE;

  always_comb begin
    w_state_nxt     = r_state;
    w_q_exp_nxt     = r_q_exp;
    w_err_flag_nxt  = r_err_flag;
    w_err_cnt_nxt   = r_err_cnt;
    w_chk_cnt_nxt   = r_chk_cnt;
    w_first_err_nxt = r_first_err;
    if (clr) begin
      w_state_nxt     = ST_UNSYNC;
      w_q_exp_nxt     = 1'b0;
      w_err_flag_nxt  = 1'b0;
      w_err_cnt_nxt   = '0;
      w_chk_cnt_nxt   = '0;
      w_first_err_nxt = '0;
    end else if (en) begin
      case (r_state)
        ST_UNSYNC: begin
          // Only a set or reset makes the model's value known
          if (j ^ k) begin
            w_q_exp_nxt = j;
            w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          w_chk_cnt_nxt = w_chk_inc;
          if (w_mismatch) begin
            w_err_cnt_nxt = w_err_inc;
            if (!r_err_flag) begin
              w_err_flag_nxt  = 1'b1;
              w_first_err_nxt = r_chk_cnt;
            end
            if (STOP_ON_ERR) w_state_nxt = ST_HALT;
          end
          case ({j, k})
            2'b01:   w_q_exp_nxt = 1'b0;
            2'b10:   w_q_exp_nxt = 1'b1;
            2'b11:   w_q_exp_nxt = ~r_q_exp;
            default: w_q_exp_nxt = r_q_exp;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_UNSYNC;
      r_q_exp     <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_cnt   <= '0;
      r_chk_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_q_exp     <= w_q_exp_nxt;
      r_err_flag  <= w_err_flag_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_chk_cnt   <= w_chk_cnt_nxt;
      r_first_err <= w_first_err_nxt;
    end
  end

  assign synced        = (r_state == ST_CHECK) || (r_state == ST_HALT);
  assign q_exp         = r_q_exp;
  assign err_flag      = r_err_flag;
  assign err_cnt       = r_err_cnt;
  assign chk_cnt       = r_chk_cnt;
  assign first_err_cyc = r_first_err;

endmodule

`default_nettype wire

// File: tb/tb_jk_ff_checker.sv
//------------------------------------------------------------------------------
// Module  : tb_jk_ff_checker
// Purpose : Directed vector bench for jk_ff_checker in three configurations.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jk_ff_checker;

  logic clk = 1'b0;
  logic rst = 1'b0, clr = 1'b0, en = 1'b1, j = 1'b0, k = 1'b0;
  logic bad = 1'b0, xq = 1'b0;
  logic m_q = 1'b0;
  logic q;

  always #5 clk = ~clk;

  // Reference JK flop standing in for the DUT; bad/xq corrupt its output
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   m_q <= 1'b0;
      2'b10:   m_q <= 1'b1;
      2'b11:   m_q <= ~m_q;
      default: m_q <= m_q;
    endcase
  end
  assign q = xq ? 1'bx : (bad ? 1'b0 : m_q);

  logic        s0, qe0, f0;
  logic [7:0]  e0;
  logic [15:0] c0, fe0;
  logic        s1, qe1, f1;
  logic [7:0]  e1;
  logic [15:0] c1, fe1;
  logic        s2, qe2, f2;
  logic [1:0]  e2;
  logic [2:0]  c2, fe2;

  jk_ff_checker u0 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .j(j), .k(k), .q(q),
    .synced(s0), .q_exp(qe0), .err_flag(f0), .err_cnt(e0), .chk_cnt(c0),
    .first_err_cyc(fe0)
  );

  jk_ff_checker #(.STOP_ON_ERR(1'b1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .j(j), .k(k), .q(q),
    .synced(s1), .q_exp(qe1), .err_flag(f1), .err_cnt(e1), .chk_cnt(c1),
    .first_err_cyc(fe1)
  );

  jk_ff_checker #(.ERR_CNT_W(2), .CHK_CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .j(j), .k(k), .q(q),
    .synced(s2), .q_exp(qe2), .err_flag(f2), .err_cnt(e2), .chk_cnt(c2),
    .first_err_cyc(fe2)
  );

  typedef struct {
    logic clr, en, j, k, bad;
    logic e_sync, e_qexp, e_flag;
    int   e_chk, e_err, e_first;
  } vec_t;

  vec_t tbl[24];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic vec_t mk(logic c, logic e, logic jj, logic kk, logic b,
                              logic es, logic eq, int ec, int ee, logic ef,
                              int efi);
    vec_t v;
    v.clr = c; v.en = e; v.j = jj; v.k = kk; v.bad = b;
    v.e_sync = es; v.e_qexp = eq; v.e_chk = ec; v.e_err = ee;
    v.e_flag = ef; v.e_first = efi;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            clr en j k bad  sync qexp chk err flag first
    tbl[0]  = mk(0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 0,   1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0,   1, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 1, 0,   1, 0, 2, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 1, 0,   1, 1, 3, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0,   1, 1, 4, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 1,   1, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 1,   1, 1, 1, 1, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 1,   1, 1, 2, 2, 1, 0);
    tbl[10] = mk(0, 1, 0, 0, 1,   1, 1, 3, 3, 1, 0);
    tbl[11] = mk(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 1, 0,   1, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 1, 0, 0,   1, 1, 1, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0,   1, 1, 2, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 1,   1, 1, 3, 1, 1, 2);
    tbl[16] = mk(0, 1, 0, 0, 0,   1, 1, 4, 1, 1, 2);
    tbl[17] = mk(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    tbl[20] = mk(0, 1, 1, 1, 0,   0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    tbl[22] = mk(0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0);
    tbl[23] = mk(0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 0);

    // Reset for two cycles, then release
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_synced", int'(s0), 0);
    check("rst_qexp",   int'(qe0), 0);
    check("rst_flag",   int'(f0), 0);
    check("rst_err",    int'(e0), 0);
    check("rst_chk",    int'(c0), 0);
    check("rst_first",  int'(fe0), 0);

    foreach (tbl[i]) begin
      clr = tbl[i].clr; en = tbl[i].en; j = tbl[i].j; k = tbl[i].k;
      bad = tbl[i].bad;
      tick();
      check($sformatf("v%0d_synced", i), int'(s0), int'(tbl[i].e_sync));
      if (tbl[i].e_sync)
        check($sformatf("v%0d_qexp", i), int'(qe0), int'(tbl[i].e_qexp));
      check($sformatf("v%0d_chk", i),   int'(c0),  tbl[i].e_chk);
      check($sformatf("v%0d_err", i),   int'(e0),  tbl[i].e_err);
      check($sformatf("v%0d_flag", i),  int'(f0),  int'(tbl[i].e_flag));
      check($sformatf("v%0d_first", i), int'(fe0), tbl[i].e_first);
    end
    clr = 1'b0; en = 1'b1; bad = 1'b0;

    // Asynchronous reset mid-CHECK takes effect without a clock edge
    rst = 1'b1;
    #2;
    check("arst_synced", int'(s0), 0);
    check("arst_chk",    int'(c0), 0);
    rst = 1'b0;

    // Unknown q counts as a mismatch
    j = 1'b1; k = 1'b0;
    tick();
    j = 1'b0; xq = 1'b1;
    tick();
    xq = 1'b0;
    check("x_err", int'(e0), 1);
    check("x_flag", int'(f0), 1);

    // Persistent mismatch: halt behaviour and saturation
    clr = 1'b1;
    tick();
    clr = 1'b0; bad = 1'b1; j = 1'b1; k = 1'b0;
    tick();
    check("halt_presync", int'(s1), 1);
    j = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check($sformatf("halt_err_e%0d", i),    int'(e1), 1);
      check($sformatf("halt_chk_e%0d", i),    int'(c1), 1);
      check($sformatf("halt_synced_e%0d", i), int'(s1), 1);
      check($sformatf("halt_qexp_e%0d", i),   int'(qe1), 1);
      if (i == 1) check("halt_flag", int'(f1), 1);
      if (i == 4) check("sat_err_e4", int'(e2), 3);
      if (i == 6) begin
        check("sat_err_e6", int'(e2), 3);
        check("sat_chk_e6", int'(c2), 6);
      end
    end
    check("sat_chk_e11", int'(c2), 7);
    check("sat_err_e11", int'(e2), 3);
    check("sat_flag",    int'(f2), 1);
    check("run_err_e11", int'(e0), 11);
    check("run_chk_e11", int'(c0), 11);
    check("run_first",   int'(fe0), 0);

    bad = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("halt_clr_synced", int'(s1), 0);
    check("halt_clr_err",    int'(e1), 0);
    check("halt_clr_chk",    int'(c1), 0);
    check("halt_clr_flag",   int'(f1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
